// File: rtl/mul_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM state encoding
// and the default sizing constants used by the top and its picker.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    WAIT    = 2'b10,
    RESPOND = 2'b11
  } arbState_t;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_NREQ    = 4;
  localparam int DEFAULT_TIMEOUT = 40;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner selection: scans pointer+1, pointer+2, ... modulo NREQ
// and returns the first asserted request. Purely combinational.
module rr_picker #(
  parameter int NREQ = mul_arb_pkg::DEFAULT_NREQ,
  localparam int PW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   pointer,
  output logic [PW-1:0]   winner,
  output logic            any
);

  logic [PW-1:0] idx;
  logic          found;
  logic          hit;

  assign any = |req;

  // Walk the requesters starting just after the last grant; first hit wins.
  always_comb begin
    winner = {PW{1'b0}};
    found  = 1'b0;
    idx    = {PW{1'b0}};
    hit    = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx    = PW'((int'(pointer) + i) % NREQ);
      hit    = req[idx] & ~found;
      winner = hit ? idx : winner;
      found  = found | req[idx];
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one sequential multiplier among NREQ requesters. Grants round-robin,
// captures the winner's operands, starts the multiplier, waits for done under
// a watchdog and returns the product (or a timeout error) to the owner.
// Every output is either a register or a decode of registered state/owner.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NREQ    = DEFAULT_NREQ,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [2*WIDTH-1:0]    rsp_product,
  output logic                  rsp_error,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic                  mul_done,
  input  logic [2*WIDTH-1:0]    mul_product,
  output logic                  mul_clear,
  output logic                  busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  arbState_t          state;
  arbState_t          nextState;
  logic [PW-1:0]      owner;
  logic [PW-1:0]      pointer;
  logic [PW-1:0]      winner;
  logic               anyReq;
  logic [CW-1:0]      count;
  logic               timeoutHit;
  logic               errorFlag;
  logic [WIDTH-1:0]   mulA;
  logic [WIDTH-1:0]   mulB;
  logic [2*WIDTH-1:0] rspProduct;
  logic [NREQ-1:0]    ownerOneHot;

  rr_picker #(.NREQ(NREQ)) picker (
    .req     (req),
    .pointer (pointer),
    .winner  (winner),
    .any     (anyReq)
  );

  // Last WAIT cycle: the watchdog fires on this edge unless done arrives too.
  assign timeoutHit  = (count == CW'(TIMEOUT - 1));
  assign ownerOneHot = NREQ'(1'b1) << owner;

  assign mul_a       = mulA;
  assign mul_b       = mulB;
  assign rsp_product = rspProduct;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; done takes priority over the watchdog in WAIT.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (anyReq) begin
          nextState = ISSUE;
        end else begin
          nextState = IDLE;
        end
      end
      ISSUE: begin
        nextState = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          nextState = RESPOND;
        end else if (timeoutHit) begin
          nextState = RESPOND;
        end else begin
          nextState = WAIT;
        end
      end
      RESPOND: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Transaction datapath: grant capture, watchdog count and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= {PW{1'b0}};
      pointer    <= PW'(NREQ - 1);
      count      <= {CW{1'b0}};
      errorFlag  <= 1'b0;
      mulA       <= {WIDTH{1'b0}};
      mulB       <= {WIDTH{1'b0}};
      rspProduct <= {(2*WIDTH){1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            owner   <= winner;
            pointer <= winner;
            mulA    <= req_a[winner*WIDTH +: WIDTH];
            mulB    <= req_b[winner*WIDTH +: WIDTH];
          end
        end
        ISSUE: begin
          count <= {CW{1'b0}};
        end
        WAIT: begin
          if (mul_done) begin
            rspProduct <= mul_product;
            errorFlag  <= 1'b0;
          end else if (timeoutHit) begin
            rspProduct <= {(2*WIDTH){1'b0}};
            errorFlag  <= 1'b1;
          end else begin
            count <= count + CW'(1'b1);
          end
        end
        RESPOND: begin
          errorFlag <= errorFlag;
        end
        default: begin
          count <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Output decode from registered state and owner only.
  always_comb begin
    ack       = {NREQ{1'b0}};
    rsp_valid = {NREQ{1'b0}};
    rsp_error = 1'b0;
    mul_start = 1'b0;
    mul_clear = 1'b0;
    busy      = (state != IDLE);
    case (state)
      ISSUE: begin
        ack       = ownerOneHot;
        mul_start = 1'b1;
      end
      RESPOND: begin
        rsp_valid = ownerOneHot;
        rsp_error = errorFlag;
        mul_clear = errorFlag;
      end
      IDLE, WAIT: begin
        mul_start = 1'b0;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule
